// File: rtl/arb_mux.sv
// arb_mux: N-to-1 arbitrating multiplexer with a registered output stage.
// Each cycle one valid input is selected, either by fixed priority (lowest
// index wins) or round-robin. The selected payload and its index are
// registered and presented on out_* one cycle later.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   per-channel request, bit i belongs to channel i
//   in_ready   per-channel accept, at most one bit high
//   in_data    packed payloads, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the beat
//   out_data   registered payload of the winning channel
//   out_sel    registered index of the winning channel
module arb_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 5,
    parameter int MODE       = 0,
    localparam int SEL_WIDTH = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]         out_sel
);

    localparam int unsigned N = NUM_IN;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [SEL_WIDTH-1:0]  sel_q,   sel_d;
    logic [SEL_WIDTH-1:0]  ptr_q,   ptr_d;

    logic [NUM_IN-1:0]     grant_oh;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic                  grant_any;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  load_en;

    // Grant search: visit channels in priority order and take the first
    // valid one. In round-robin mode the order starts at ptr and wraps.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (MODE == 1) begin
                idx = 32'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
            end else begin
                idx = k;
            end
            if (!grant_any && in_valid[idx]) begin
                grant_any     = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = SEL_WIDTH'(idx);
            end
        end
    end

    // One-hot AND-OR select keeps the payload path free of index decoding.
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_oh[i]) begin
                grant_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign load_en  = !valid_q || out_ready;
    assign in_ready = load_en ? grant_oh : '0;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (grant_any && load_en) begin
            valid_d = 1'b1;
            data_d  = grant_data;
            sel_d   = grant_idx;
            if (MODE == 1) begin
                if (32'(grant_idx) == N - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_idx + 1'b1;
                end
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
